hmm_seq_gen: RTL and testbench

HMM_SEQ_GEN -- requirements
Module: hmm_seq_gen

---
 rtl/hmm_seq_gen.sv | 157 +++++++++++++++
 tb/tb_hmm_seq_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmm_seq_gen.sv
// HMM sequence generator: draws a hidden path and observation stream (3 states, 3 symbols)
// from cumulative threshold tables, using a 16-bit Galois LFSR as the random source.
module hmm_seq_gen #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int          TW   = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic [2:0]    length,
    input  logic [15:0]   seed_in,
    input  logic          seed_we,
    input  logic [TW-1:0] cumC_0,
    input  logic [TW-1:0] cumC_1,
    input  logic [TW-1:0] cumA_0,
    input  logic [TW-1:0] cumA_1,
    input  logic [TW-1:0] cumA_2,
    input  logic [TW-1:0] cumA_3,
    input  logic [TW-1:0] cumA_4,
    input  logic [TW-1:0] cumA_5,
    input  logic [TW-1:0] cumB_0,
    input  logic [TW-1:0] cumB_1,
    input  logic [TW-1:0] cumB_2,
    input  logic [TW-1:0] cumB_3,
    input  logic [TW-1:0] cumB_4,
    input  logic [TW-1:0] cumB_5,
    output logic          start,
    output logic [2:0]    length_out,
    output logic [1:0]    obs_out,
    output logic          obs_valid,
    output logic [1:0]    state_0,
    output logic [1:0]    state_1,
    output logic [1:0]    state_2,
    output logic [1:0]    state_3,
    output logic [1:0]    state_4,
    output logic [1:0]    state_5,
    output logic [1:0]    state_6,
    output logic          busy,
    output logic          ready,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, DRAW_S, DRAW_O, EMIT, GAP, FIN} fsm_t;

    fsm_t            state, state_nx;
    logic [15:0]     lfsr, lfsr_nx;
    logic [2:0]      t, len;
    logic [7:0][1:0] path;
    logic [1:0]      obs_sel, sel_s, sel_o;
    logic [TW-1:0]   r, tc0, tc1, ec0, ec1;

    function automatic logic [1:0] pick(input logic [TW-1:0] rv, input logic [TW-1:0] c0,
                                        input logic [TW-1:0] c1);
        if (rv < c0)      return 2'd0;
        else if (rv < c1) return 2'd1;
        else              return 2'd2;
    endfunction

    assign r       = TW'(lfsr[7:0]);
    assign lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Threshold rows: initial-state row for t=0, otherwise the row of the previous state.
    always_comb begin
        tc0 = cumC_0;
        tc1 = cumC_1;
        if (t != 3'd0) begin
            case (path[t - 3'd1])
                2'd0:    begin tc0 = cumA_0; tc1 = cumA_1; end
                2'd1:    begin tc0 = cumA_2; tc1 = cumA_3; end
                default: begin tc0 = cumA_4; tc1 = cumA_5; end
            endcase
        end
        sel_s = pick(r, tc0, tc1);
        ec0 = cumB_4;
        ec1 = cumB_5;
        case (path[t])
            2'd0:    begin ec0 = cumB_0; ec1 = cumB_1; end
            2'd1:    begin ec0 = cumB_2; ec1 = cumB_3; end
            default: begin ec0 = cumB_4; ec1 = cumB_5; end
        endcase
        sel_o = pick(r, ec0, ec1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go && length != 3'd0) state_nx = DRAW_S;
            DRAW_S:  state_nx = DRAW_O;
            DRAW_O:  state_nx = EMIT;
            EMIT:    state_nx = (t == len - 3'd1) ? FIN : GAP;
            GAP:     state_nx = DRAW_S;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= SEED;
            t         <= 3'd0;
            len       <= 3'd0;
            path      <= '0;
            obs_sel   <= 2'd0;
            obs_out   <= 2'd0;
            start     <= 1'b0;
            obs_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            state     <= state_nx;
            start     <= 1'b0;
            obs_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= (state_nx != IDLE);
            ready     <= (state_nx == IDLE);
            case (state)
                IDLE: begin
                    // A seed load in the same cycle as go is seen by the first draw.
                    if (seed_we) lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
                    if (go && length != 3'd0) begin
                        len  <= length;
                        t    <= 3'd0;
                        path <= '0;
                    end
                end
                DRAW_S: begin
                    path[t] <= sel_s;
                    lfsr    <= lfsr_nx;
                end
                DRAW_O: begin
                    obs_sel <= sel_o;
                    lfsr    <= lfsr_nx;
                end
                EMIT: begin
                    obs_out   <= obs_sel;
                    start     <= (t == 3'd0);
                    obs_valid <= (t != 3'd0);
                end
                GAP:     t    <= t + 3'd1;
                FIN:     done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign length_out = len;
    assign state_0    = path[0];
    assign state_1    = path[1];
    assign state_2    = path[2];
    assign state_3    = path[3];
    assign state_4    = path[4];
    assign state_5    = path[5];
    assign state_6    = path[6];

endmodule

// File: tb/tb_hmm_seq_gen.sv
// Bench for hmm_seq_gen: fixed-outcome vector table, LFSR reference model with an
// observation scoreboard, and hand-written ignore/seed/reset sequences.
module tb_hmm_seq_gen;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0, rst_n, go, seed_we;
    logic [2:0] length;
    logic [15:0] seed_in;
    logic [8:0] cumC_0, cumC_1, cumA_0, cumA_1, cumA_2, cumA_3, cumA_4, cumA_5;
    logic [8:0] cumB_0, cumB_1, cumB_2, cumB_3, cumB_4, cumB_5;
    logic start, obs_valid, busy, ready, done;
    logic [2:0] length_out;
    logic [1:0] obs_out, state_0, state_1, state_2, state_3, state_4, state_5, state_6;

    hmm_seq_gen #(.SEED(SEED), .TW(9)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .length(length), .seed_in(seed_in), .seed_we(seed_we),
        .cumC_0(cumC_0), .cumC_1(cumC_1),
        .cumA_0(cumA_0), .cumA_1(cumA_1), .cumA_2(cumA_2), .cumA_3(cumA_3), .cumA_4(cumA_4), .cumA_5(cumA_5),
        .cumB_0(cumB_0), .cumB_1(cumB_1), .cumB_2(cumB_2), .cumB_3(cumB_3), .cumB_4(cumB_4), .cumB_5(cumB_5),
        .start(start), .length_out(length_out), .obs_out(obs_out), .obs_valid(obs_valid),
        .state_0(state_0), .state_1(state_1), .state_2(state_2), .state_3(state_3),
        .state_4(state_4), .state_5(state_5), .state_6(state_6),
        .busy(busy), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    typedef logic [6:0][1:0] seq_t;
    typedef struct packed {
        logic [1:0][8:0] c;
        logic [5:0][8:0] a;
        logic [5:0][8:0] b;
    } cfg_t;
    typedef struct {
        cfg_t cfg;
        int   len;
        seq_t p;
        seq_t o;
    } vec_t;
    typedef struct packed {
        logic       first;
        logic [1:0] obs;
    } exp_t;

    int n_cmp = 0, n_err = 0;
    logic [15:0] m_lfsr;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [1:0] pick(input logic [8:0] rv, input logic [8:0] c0, input logic [8:0] c1);
        if (rv < c0) return 2'd0;
        if (rv < c1) return 2'd1;
        return 2'd2;
    endfunction

    function automatic cfg_t mk_cfg(input int c0, c1, a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5);
        cfg_t k;
        k.c[0] = 9'(c0); k.c[1] = 9'(c1);
        k.a[0] = 9'(a0); k.a[1] = 9'(a1); k.a[2] = 9'(a2);
        k.a[3] = 9'(a3); k.a[4] = 9'(a4); k.a[5] = 9'(a5);
        k.b[0] = 9'(b0); k.b[1] = 9'(b1); k.b[2] = 9'(b2);
        k.b[3] = 9'(b3); k.b[4] = 9'(b4); k.b[5] = 9'(b5);
        return k;
    endfunction

    function automatic seq_t mk_seq(input int s0, s1, s2, s3, s4, s5, s6);
        seq_t s;
        s[0] = 2'(s0); s[1] = 2'(s1); s[2] = 2'(s2); s[3] = 2'(s3);
        s[4] = 2'(s4); s[5] = 2'(s5); s[6] = 2'(s6);
        return s;
    endfunction

    function automatic cfg_t rnd_cfg();
        cfg_t k;
        int x;
        for (int j = 0; j < 8; j++) begin
            x = int'($urandom_range(256, 0));
            if (j == 0) begin k.c[0] = 9'(x); k.c[1] = 9'($urandom_range(256, x)); end
            else if (j < 4) begin k.a[2*(j-1)] = 9'(x); k.a[2*(j-1)+1] = 9'($urandom_range(256, x)); end
            else if (j < 7) begin k.b[2*(j-4)] = 9'(x); k.b[2*(j-4)+1] = 9'($urandom_range(256, x)); end
        end
        return k;
    endfunction

    task automatic set_cfg(input cfg_t k);
        cumC_0 = k.c[0]; cumC_1 = k.c[1];
        cumA_0 = k.a[0]; cumA_1 = k.a[1]; cumA_2 = k.a[2];
        cumA_3 = k.a[3]; cumA_4 = k.a[4]; cumA_5 = k.a[5];
        cumB_0 = k.b[0]; cumB_1 = k.b[1]; cumB_2 = k.b[2];
        cumB_3 = k.b[3]; cumB_4 = k.b[4]; cumB_5 = k.b[5];
    endtask

    // Reference: state draw then observation draw, each consuming one LFSR step.
    task automatic model(input cfg_t k, input int len, output seq_t p, output seq_t o);
        logic [1:0] s, prev;
        p = '0; o = '0; prev = 2'd0;
        for (int t = 0; t < len; t++) begin
            if (t == 0) s = pick({1'b0, m_lfsr[7:0]}, k.c[0], k.c[1]);
            else        s = pick({1'b0, m_lfsr[7:0]}, k.a[2*prev], k.a[2*prev+1]);
            m_lfsr = step(m_lfsr);
            o[t] = pick({1'b0, m_lfsr[7:0]}, k.b[2*s], k.b[2*s+1]);
            m_lfsr = step(m_lfsr);
            p[t] = s;
            prev = s;
        end
    endtask

    task automatic run_seq(input cfg_t k, input int len, input bit use_tab, input seq_t tp, input seq_t to,
                           input bit do_seed, input logic [15:0] sd, input bit inject,
                           output seq_t got_p, output seq_t got_o);
        seq_t ep, eo;
        exp_t e;
        int ti;
        set_cfg(k);
        if (do_seed) m_lfsr = (sd == 16'h0000) ? SEED : sd;
        model(k, len, ep, eo);
        if (use_tab) begin ep = tp; eo = to; end
        for (int t = 0; t < len; t++) begin
            e.first = (t == 0); e.obs = eo[t];
            exp_q.push_back(e);
        end
        got_p = '0; got_o = '0; ti = 0;
        @(negedge clk);
        go = 1'b1; length = 3'(len); seed_we = do_seed; seed_in = sd;
        @(negedge clk);
        go = 1'b0; seed_we = 1'b0;
        for (int i = 0; i <= 4*len + 1; i++) begin
            if (i > 0) @(negedge clk);
            if (inject && i == 1) begin go = 1'b1; seed_we = 1'b1; seed_in = 16'h5A5A; length = 3'd2; end
            if (inject && i == 2) begin go = 1'b0; seed_we = 1'b0; end
            chk("start_timing", 32'(start), 32'(i == 3));
            chk("obs_valid_timing", 32'(obs_valid), 32'(i > 3 && (i - 3) % 4 == 0 && (i - 3) / 4 < len));
            chk("done_timing", 32'(done), 32'(i == 4*len));
            chk("busy", 32'(busy), 32'(i < 4*len));
            chk("ready", 32'(ready), 32'(i >= 4*len));
            if (start || obs_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_underflow: got unexpected observation 0x%0h at cycle %0d", obs_out, i);
                end else begin
                    e = exp_q.pop_front();
                    chk("obs", 32'(obs_out), 32'(e.obs));
                    chk("first_flag", 32'(start), 32'(e.first));
                    if (ti < 7) got_o[ti] = obs_out;
                    ti++;
                end
            end
        end
        got_p = {state_6, state_5, state_4, state_3, state_2, state_1, state_0};
        chk("path", 32'(got_p), 32'(ep));
        chk("length_out", 32'(length_out), 32'(len));
        chk("lfsr_track", 32'(dut.lfsr), 32'(m_lfsr));
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[4];
        seq_t pa, oa, pb, ob, dp, dob;
        cfg_t k;
        int pulses;

        tab[0].cfg = mk_cfg(256,256, 0,256, 0,0, 0,0, 256,256, 0,256, 0,0);
        tab[0].len = 3; tab[0].p = mk_seq(0,1,2,0,0,0,0); tab[0].o = mk_seq(0,1,2,0,0,0,0);
        tab[1].cfg = mk_cfg(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0);
        tab[1].len = 7; tab[1].p = mk_seq(2,2,2,2,2,2,2); tab[1].o = mk_seq(2,2,2,2,2,2,2);
        tab[2].cfg = mk_cfg(0,256, 17,99, 3,200, 50,60, 0,0, 256,256, 0,0);
        tab[2].len = 1; tab[2].p = mk_seq(1,0,0,0,0,0,0); tab[2].o = mk_seq(0,0,0,0,0,0,0);
        tab[3].cfg = mk_cfg(256,256, 0,256, 0,0, 256,256, 0,256, 0,0, 256,256);
        tab[3].len = 5; tab[3].p = mk_seq(0,1,2,0,1,0,0); tab[3].o = mk_seq(1,2,0,1,2,0,0);

        rst_n = 1'b0; go = 1'b0; seed_we = 1'b0; length = 3'd0; seed_in = 16'h0;
        set_cfg(mk_cfg(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0));
        m_lfsr = SEED;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_obs_valid", 32'(obs_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_obs_out", 32'(obs_out), 32'd0);
        chk("rst_length_out", 32'(length_out), 32'd0);
        chk("rst_path", 32'({state_6, state_5, state_4, state_3, state_2, state_1, state_0}), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr), 32'(SEED));
        rst_n = 1'b1;

        // Fixed-outcome vectors; the second one also has go/seed_we poked while busy
        for (int v = 0; v < 4; v++)
            run_seq(tab[v].cfg, tab[v].len, 1'b1, tab[v].p, tab[v].o, 1'b0, 16'h0, v == 1, dp, dob);

        // go with length 0 must be ignored
        @(negedge clk); go = 1'b1; length = 3'd0;
        @(negedge clk); go = 1'b0;
        chk("len0_ready", 32'(ready), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_length_out", 32'(length_out), 32'd5);
        chk("len0_lfsr", 32'(dut.lfsr), 32'(m_lfsr));
        @(negedge clk); @(negedge clk);
        chk("len0_no_start", 32'(start), 32'd0);

        // Reproducibility from a loaded seed
        k = rnd_cfg();
        run_seq(k, 7, 1'b0, '0, '0, 1'b1, 16'h1234, 1'b0, pa, oa);
        run_seq(k, 7, 1'b0, '0, '0, 1'b1, 16'h1234, 1'b1, pb, ob);
        chk("repro_obs", 32'(ob), 32'(oa));
        chk("repro_path", 32'(pb), 32'(pa));

        // A zero seed falls back to SEED
        k = rnd_cfg();
        run_seq(k, 6, 1'b0, '0, '0, 1'b1, 16'h0000, 1'b0, pa, oa);
        run_seq(k, 6, 1'b0, '0, '0, 1'b1, SEED, 1'b0, pb, ob);
        chk("seed0_obs", 32'(ob), 32'(oa));
        chk("seed0_path", 32'(pb), 32'(pa));

        // Free-running random configurations and lengths
        for (int n = 0; n < 5; n++)
            run_seq(rnd_cfg(), int'($urandom_range(7, 1)), 1'b0, '0, '0, 1'b0, 16'h0, 1'b0, dp, dob);

        // Reset in the EMIT cycle of t=1 aborts the run
        set_cfg(rnd_cfg());
        @(negedge clk); go = 1'b1; length = 3'd7;
        @(negedge clk); go = 1'b0;
        for (int i = 1; i <= 6; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_obs_valid", 32'(obs_valid), 32'd0);
        chk("abort_start", 32'(start), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_obs_out", 32'(obs_out), 32'd0);
        chk("abort_length_out", 32'(length_out), 32'd0);
        chk("abort_path", 32'({state_6, state_5, state_4, state_3, state_2, state_1, state_0}), 32'd0);
        chk("abort_lfsr", 32'(dut.lfsr), 32'(SEED));
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (start || obs_valid || done) pulses++;
        end
        chk("abort_no_pulses", 32'(pulses), 32'd0);
        m_lfsr = SEED;
        run_seq(rnd_cfg(), 4, 1'b0, '0, '0, 1'b0, 16'h0, 1'b0, dp, dob);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
